// File: rtl/uart_lite_slave_pkg.sv
// ---------------------------------------------------------------------------
// uart_lite_pkg
// Shared definitions for the UART-lite AXI4-Lite slave:
//   - register offsets (decoded from address bits [3:2])
//   - STAT bit positions and CTRL flush bit positions
//   - AXI response codes
//   - read/write FSM state enums
//   - packStatus(): assembles the STAT word from the FIFO/overrun flags
// ---------------------------------------------------------------------------
package uart_lite_pkg;

  // Register selectors, i.e. address bits [3:2]
  localparam logic [1:0] REG_RX   = 2'd0;  // 0x0 : RX FIFO, read pops
  localparam logic [1:0] REG_TX   = 2'd1;  // 0x4 : TX FIFO, write pushes
  localparam logic [1:0] REG_STAT = 2'd2;  // 0x8 : status, read-only
  localparam logic [1:0] REG_CTRL = 2'd3;  // 0xC : control, write-only

  // STAT bit positions
  localparam int STAT_RX_NOT_EMPTY = 0;
  localparam int STAT_RX_FULL      = 1;
  localparam int STAT_TX_EMPTY     = 2;
  localparam int STAT_TX_FULL      = 3;
  localparam int STAT_RX_OVERRUN   = 5;

  // CTRL bit positions
  localparam int CTRL_TX_FLUSH = 0;
  localparam int CTRL_RX_FLUSH = 1;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {R_IDLE, R_RESP} rdState_e;
  typedef enum logic {W_IDLE, W_RESP} wrState_e;

  // Builds the STAT word; every bit not listed stays zero.
  function automatic logic [31:0] packStatus(input logic rxNotEmpty,
                                             input logic rxFull,
                                             input logic txEmpty,
                                             input logic txFull,
                                             input logic overrun);
    logic [31:0] s;
    s = '0;
    s[STAT_RX_NOT_EMPTY] = rxNotEmpty;
    s[STAT_RX_FULL]      = rxFull;
    s[STAT_TX_EMPTY]     = txEmpty;
    s[STAT_TX_FULL]      = txFull;
    s[STAT_RX_OVERRUN]   = overrun;
    return s;
  endfunction

endpackage

// File: rtl/uart_lite_slave_if.sv
// ---------------------------------------------------------------------------
// uart_lite_slave_if
// AXI4-Lite bus bundle between a master and the UART-lite slave.
//   Read  : ARADDR[3:0] ARVALID ARREADY RDATA[31:0] RRESP[1:0] RVALID RREADY
//   Write : AWADDR[3:0] AWVALID AWREADY WDATA[31:0] WSTRB[3:0] WVALID WREADY
//           BRESP[1:0] BVALID BREADY
// Modports: master drives addresses/data/ready-for-response, slave answers.
// ---------------------------------------------------------------------------
interface uart_lite_slave_if;
  import uart_lite_pkg::*;

  logic [3:0]  ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;

  logic [3:0]  AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;

  modport master (
    output ARADDR, ARVALID, RREADY,
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    input  ARREADY, RDATA, RRESP, RVALID,
    input  AWREADY, WREADY, BRESP, BVALID
  );

  modport slave (
    input  ARADDR, ARVALID, RREADY,
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    output ARREADY, RDATA, RRESP, RVALID,
    output AWREADY, WREADY, BRESP, BVALID
  );

endinterface

// File: rtl/uart_lite_slave_fifo.sv
// ---------------------------------------------------------------------------
// uart_fifo
// Synchronous FIFO with flush.
//   CLK, RST_N : clock, synchronous active-low reset
//   push_i     : write data_i (accepted when not full, or when popping too)
//   pop_i      : drop the head entry
//   flush_i    : empty the FIFO; wins over a same-cycle push/pop
//   data_o     : head entry, forced to zero while empty
//   full_o, empty_o, count_o : occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module uart_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PTR_W:0]   count_o
);

  localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q;
  logic [PTR_W-1:0] rdPtr_q;
  logic [PTR_W:0]   count_q;
  logic             doPush;
  logic             doPop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_COUNT);
  assign count_o = count_q;
  assign data_o  = empty_o ? '0 : mem_q[rdPtr_q];

  // A push into a full FIFO is only legal alongside a pop, and a pop of an
  // empty FIFO only alongside a push, so push+pop always leaves count alone.
  assign doPush = push_i & (~full_o  | pop_i);
  assign doPop  = pop_i  & (~empty_o | push_i);

  // Pointers and occupancy; flush behaves like reset.
  always_ff @(posedge CLK) begin
    if (!RST_N || flush_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage has no reset; data_o masks it until something is written.
  always_ff @(posedge CLK) begin
    if (doPush && !flush_i) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/uart_lite_slave.sv
// ---------------------------------------------------------------------------
// uart_lite_slave
// AXI4-Lite register front end for a UART byte stream.
//   CLK, RST_N : clock, synchronous active-low reset
//   bus        : AXI4-Lite slave port (uart_lite_slave_if.slave)
//   TX_DATA/TX_VALID/TX_READY : outgoing bytes, head of the TX FIFO
//   RX_DATA/RX_VALID          : incoming bytes, one-cycle strobe each
// Registers: 0x0 RX pop, 0x4 TX push, 0x8 STAT, 0xC CTRL (flush bits).
// Read and write paths are independent FSMs.
// ---------------------------------------------------------------------------
module uart_lite_slave
  import uart_lite_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic               CLK,
  input  logic               RST_N,
  uart_lite_slave_if.slave   bus,
  output logic [7:0]         TX_DATA,
  output logic               TX_VALID,
  input  logic               TX_READY,
  input  logic [7:0]         RX_DATA,
  input  logic               RX_VALID
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  rdState_e    rState_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;

  wrState_e    wState_q;
  logic        awDone_q;
  logic        wDone_q;
  logic [1:0]  awAddr_q;
  logic [7:0]  wData_q;
  logic        wStrb0_q;
  logic [1:0]  bresp_q;

  logic        overrun_q;

  logic [7:0]       rxData;
  logic             rxFull, rxEmpty, txFull, txEmpty;
  logic [CNT_W-1:0] rxCount, txCount;

  logic        arHs, awHs, wHs;
  logic        rxPop, txPop, txPush, rxFlush, txFlush;
  logic        doAction, txWrite, txDrop, ctrlWrite;
  logic        overrunSet, overrunClr;
  logic [1:0]  wrResp;
  logic [31:0] statusWord;
  logic [31:0] rdMux;
  logic        unusedBits;

  assign bus.ARREADY = (rState_q == R_IDLE);
  assign bus.RVALID  = (rState_q == R_RESP);
  assign bus.RDATA   = rdata_q;
  assign bus.RRESP   = rresp_q;

  assign bus.AWREADY = (wState_q == W_IDLE) & ~awDone_q;
  assign bus.WREADY  = (wState_q == W_IDLE) & ~wDone_q;
  assign bus.BVALID  = (wState_q == W_RESP);
  assign bus.BRESP   = bresp_q;

  assign arHs = bus.ARVALID & bus.ARREADY;
  assign awHs = bus.AWVALID & bus.AWREADY;
  assign wHs  = bus.WVALID  & bus.WREADY;

  // RX pops only on a real byte; an empty read just returns the zero head.
  assign rxPop = arHs & (bus.ARADDR[3:2] == REG_RX) & ~rxEmpty;
  assign txPop = TX_VALID & TX_READY;

  // The register action fires the cycle after both AW and W are latched.
  assign doAction  = (wState_q == W_IDLE) & awDone_q & wDone_q;
  assign txWrite   = doAction & (awAddr_q == REG_TX) & wStrb0_q;
  assign txDrop    = txWrite & txFull & ~txPop;
  assign txPush    = txWrite & ~txDrop;
  assign wrResp    = txDrop ? RESP_SLVERR : RESP_OKAY;
  assign ctrlWrite = doAction & (awAddr_q == REG_CTRL);
  assign txFlush   = ctrlWrite & wData_q[CTRL_TX_FLUSH];
  assign rxFlush   = ctrlWrite & wData_q[CTRL_RX_FLUSH];

  // A strobe into a full FIFO is only lost if no pop frees a slot.
  assign overrunSet = RX_VALID & rxFull & ~rxPop;
  assign overrunClr = arHs & (bus.ARADDR[3:2] == REG_STAT);

  assign statusWord = packStatus(~rxEmpty, rxFull, txEmpty, txFull, overrun_q);

  assign TX_VALID = ~txEmpty;

  assign unusedBits = ^{bus.ARADDR[1:0], bus.AWADDR[1:0], bus.WDATA[31:8],
                        bus.WSTRB[3:1], rxCount, txCount};

  // Read data selection at AR handshake time.
  always_comb begin
    rdMux = '0;
    case (bus.ARADDR[3:2])
      REG_RX:   rdMux = {24'h0, rxData};
      REG_STAT: rdMux = statusWord;
      default:  rdMux = '0;
    endcase
  end

  // Read FSM: capture the response on the AR handshake, hold until RREADY.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rState_q <= R_IDLE;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      case (rState_q)
        R_IDLE: begin
          if (bus.ARVALID) begin
            rdata_q  <= rdMux;
            rresp_q  <= RESP_OKAY;
            rState_q <= R_RESP;
          end
        end
        R_RESP: begin
          if (bus.RREADY) rState_q <= R_IDLE;
        end
        default: rState_q <= R_IDLE;
      endcase
    end
  end

  // Write FSM: AW and W are latched independently, then one action cycle
  // produces BRESP and moves to W_RESP until BREADY.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wState_q <= W_IDLE;
      awDone_q <= 1'b0;
      wDone_q  <= 1'b0;
      awAddr_q <= '0;
      wData_q  <= '0;
      wStrb0_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      case (wState_q)
        W_IDLE: begin
          if (awDone_q && wDone_q) begin
            bresp_q  <= wrResp;
            awDone_q <= 1'b0;
            wDone_q  <= 1'b0;
            wState_q <= W_RESP;
          end else begin
            if (awHs) begin
              awDone_q <= 1'b1;
              awAddr_q <= bus.AWADDR[3:2];
            end
            if (wHs) begin
              wDone_q  <= 1'b1;
              wData_q  <= bus.WDATA[7:0];
              wStrb0_q <= bus.WSTRB[0];
            end
          end
        end
        W_RESP: begin
          if (bus.BREADY) wState_q <= W_IDLE;
        end
        default: wState_q <= W_IDLE;
      endcase
    end
  end

  // Sticky overrun flag; a new overrun beats a same-cycle STAT read clear.
  always_ff @(posedge CLK) begin
    if (!RST_N)          overrun_q <= 1'b0;
    else if (overrunSet) overrun_q <= 1'b1;
    else if (overrunClr) overrun_q <= 1'b0;
  end

  uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rxFifo (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .push_i  (RX_VALID),
    .pop_i   (rxPop),
    .flush_i (rxFlush),
    .data_i  (RX_DATA),
    .data_o  (rxData),
    .full_o  (rxFull),
    .empty_o (rxEmpty),
    .count_o (rxCount)
  );

  uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_txFifo (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .push_i  (txPush),
    .pop_i   (txPop),
    .flush_i (txFlush),
    .data_i  (wData_q),
    .data_o  (TX_DATA),
    .full_o  (txFull),
    .empty_o (txEmpty),
    .count_o (txCount)
  );

endmodule

// File: tb/tb_uart_lite_slave.sv
// ---------------------------------------------------------------------------
// tb_uart_lite_slave
// Directed bench for uart_lite_slave with FIFO_DEPTH=16. Inputs change and
// outputs are sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_uart_lite_slave;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [7:0] TX_DATA;
  logic       TX_VALID;
  logic       TX_READY;
  logic [7:0] RX_DATA;
  logic       RX_VALID;

  int checks = 0;
  int errors = 0;

  uart_lite_slave_if bus ();

  uart_lite_slave #(.FIFO_DEPTH(16)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .bus      (bus),
    .TX_DATA  (TX_DATA),
    .TX_VALID (TX_VALID),
    .TX_READY (TX_READY),
    .RX_DATA  (RX_DATA),
    .RX_VALID (RX_VALID)
  );

  always #5 CLK = ~CLK;

  // Advance one clock and land just after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic doReset();
    RST_N = 1'b0;
    step();
    step();
    RST_N = 1'b1;
  endtask

  task automatic strobeRx(input logic [7:0] b);
    RX_DATA  = b;
    RX_VALID = 1'b1;
    step();
    RX_VALID = 1'b0;
  endtask

  // Full read transaction with RREADY high; returns RDATA/RRESP.
  task automatic axiRead(input logic [3:0] addr, output logic [31:0] data,
                         output logic [1:0] resp);
    int n;
    bus.ARADDR  = addr;
    bus.ARVALID = 1'b1;
    bus.RREADY  = 1'b1;
    n = 0;
    while (bus.ARREADY !== 1'b1 && n < 20) begin step(); n++; end
    step();
    bus.ARVALID = 1'b0;
    n = 0;
    while (bus.RVALID !== 1'b1 && n < 20) begin step(); n++; end
    checks++;
    if (bus.RVALID !== 1'b1) begin
      errors++;
      $display("[TB] FAIL read_timeout addr=%h got RVALID=%b want 1", addr, bus.RVALID);
    end
    data = bus.RDATA;
    resp = bus.RRESP;
    step();
    bus.RREADY = 1'b0;
  endtask

  // Write transaction; AW/W become valid at cycle awStart/wStart.
  task automatic axiWrite(input logic [3:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int awStart,
                          input int wStart, output logic [1:0] resp);
    logic awDone = 1'b0;
    logic wDone  = 1'b0;
    logic awHit, wHit;
    int   n;
    bus.AWADDR = addr;
    bus.WDATA  = data;
    bus.WSTRB  = strb;
    for (int c = 0; c < 40 && !(awDone && wDone); c++) begin
      bus.AWVALID = !awDone && (c >= awStart);
      bus.WVALID  = !wDone  && (c >= wStart);
      awHit = bus.AWVALID && bus.AWREADY;
      wHit  = bus.WVALID  && bus.WREADY;
      step();
      awDone = awDone | awHit;
      wDone  = wDone  | wHit;
    end
    bus.AWVALID = 1'b0;
    bus.WVALID  = 1'b0;
    bus.BREADY  = 1'b1;
    n = 0;
    while (bus.BVALID !== 1'b1 && n < 20) begin step(); n++; end
    checks++;
    if (bus.BVALID !== 1'b1) begin
      errors++;
      $display("[TB] FAIL write_timeout addr=%h got BVALID=%b want 1", addr, bus.BVALID);
    end
    resp = bus.BRESP;
    step();
    bus.BREADY = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    checks++;
    if ({bus.ARREADY, bus.AWREADY, bus.WREADY, bus.RVALID, bus.BVALID, TX_VALID} !== 6'b111000) begin
      errors++;
      $display("[TB] FAIL reset_flags got %b want 111000",
               {bus.ARREADY, bus.AWREADY, bus.WREADY, bus.RVALID, bus.BVALID, TX_VALID});
    end
    checks++;
    if (bus.RDATA !== 32'h0 || bus.RRESP !== 2'b00 || bus.BRESP !== 2'b00 || TX_DATA !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_data got RDATA=%h RRESP=%b BRESP=%b TX_DATA=%h want all zero",
               bus.RDATA, bus.RRESP, bus.BRESP, TX_DATA);
    end
  endtask

  task automatic test_rx_read();
    logic [31:0] d;
    logic [1:0]  r;
    logic [7:0]  exp [3];
    exp[0] = 8'h41; exp[1] = 8'h42; exp[2] = 8'h43;
    for (int i = 0; i < 3; i++) strobeRx(exp[i]);
    axiRead(4'h8, d, r);
    checks++;
    if (d !== 32'h5) begin
      errors++;
      $display("[TB] FAIL rx_stat_loaded got %h want 00000005", d);
    end
    for (int i = 0; i < 3; i++) begin
      axiRead(4'h0, d, r);
      checks++;
      if (d !== {24'h0, exp[i]} || r !== 2'b00) begin
        errors++;
        $display("[TB] FAIL rx_pop%0d got %h/%b want %h/00", i, d, r, {24'h0, exp[i]});
      end
    end
    axiRead(4'h0, d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b00) begin
      errors++;
      $display("[TB] FAIL rx_empty_read got %h/%b want 00000000/00", d, r);
    end
    axiRead(4'h8, d, r);
    checks++;
    if (d !== 32'h4) begin
      errors++;
      $display("[TB] FAIL rx_stat_drained got %h want 00000004", d);
    end
  endtask

  task automatic test_tx_write();
    logic [1:0] r;
    TX_READY = 1'b0;
    axiWrite(4'h4, 32'h0000_005A, 4'hF, 0, 2, r);
    checks++;
    if (r !== 2'b00) begin
      errors++;
      $display("[TB] FAIL tx_bresp got %b want 00", r);
    end
    checks++;
    if (bus.BVALID !== 1'b0) begin
      errors++;
      $display("[TB] FAIL tx_single_bvalid got BVALID=%b want 0", bus.BVALID);
    end
    checks++;
    if (TX_VALID !== 1'b1 || TX_DATA !== 8'h5A) begin
      errors++;
      $display("[TB] FAIL tx_head got %b/%h want 1/5a", TX_VALID, TX_DATA);
    end
    TX_READY = 1'b1;
    step();
    TX_READY = 1'b0;
    checks++;
    if (TX_VALID !== 1'b0) begin
      errors++;
      $display("[TB] FAIL tx_popped got TX_VALID=%b want 0", TX_VALID);
    end
  endtask

  task automatic test_misc_regs();
    logic [31:0] d;
    logic [1:0]  r0, r8, rs;
    axiWrite(4'h0, 32'h0000_00AB, 4'hF, 3, 0, r0);
    axiWrite(4'h8, 32'hFFFF_FFFF, 4'hF, 0, 0, r8);
    axiWrite(4'h4, 32'h0000_0099, 4'h0, 0, 0, rs);
    checks++;
    if ({r0, r8, rs} !== 6'b000000) begin
      errors++;
      $display("[TB] FAIL misc_bresp got %b want 000000", {r0, r8, rs});
    end
    axiRead(4'h8, d, r0);
    checks++;
    if (d !== 32'h4 || TX_VALID !== 1'b0) begin
      errors++;
      $display("[TB] FAIL misc_no_effect got STAT=%h TX_VALID=%b want 00000004/0", d, TX_VALID);
    end
    axiRead(4'h4, d, r0);
    axiRead(4'hC, d, r8);
    checks++;
    if (d !== 32'h0 || r0 !== 2'b00 || r8 !== 2'b00) begin
      errors++;
      $display("[TB] FAIL misc_reads got %h/%b/%b want 0/00/00", d, r0, r8);
    end
  endtask

  task automatic test_tx_full();
    logic [31:0] d;
    logic [1:0]  r;
    logic        badResp = 1'b0;
    TX_READY = 1'b0;
    for (int i = 0; i < 16; i++) begin
      axiWrite(4'h4, 32'h10 + i, 4'h1, 0, 0, r);
      if (r !== 2'b00) badResp = 1'b1;
    end
    checks++;
    if (badResp !== 1'b0) begin
      errors++;
      $display("[TB] FAIL txfill_resp got a non-OKAY response want all 00");
    end
    axiRead(4'h8, d, r);
    checks++;
    if (d !== 32'h8) begin
      errors++;
      $display("[TB] FAIL txfull_stat got %h want 00000008", d);
    end
    axiWrite(4'h4, 32'hEE, 4'h1, 0, 0, r);
    checks++;
    if (r !== 2'b10) begin
      errors++;
      $display("[TB] FAIL txfull_slverr got %b want 10", r);
    end
    TX_READY = 1'b1;
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (TX_VALID !== 1'b1 || TX_DATA !== 8'(8'h10 + i)) begin
        errors++;
        $display("[TB] FAIL txdrain%0d got %b/%h want 1/%h", i, TX_VALID, TX_DATA, 8'(8'h10 + i));
      end
      step();
    end
    TX_READY = 1'b0;
    checks++;
    if (TX_VALID !== 1'b1 || TX_DATA !== 8'h1F) begin
      errors++;
      $display("[TB] FAIL txdrain_last got %b/%h want 1/1f", TX_VALID, TX_DATA);
    end
  endtask

  task automatic test_overrun();
    logic [31:0] d;
    logic [1:0]  r;
    for (int i = 0; i < 17; i++) begin
      RX_DATA  = 8'(8'h60 + i);
      RX_VALID = 1'b1;
      step();
    end
    RX_VALID = 1'b0;
    axiRead(4'h8, d, r);
    checks++;
    if (d !== 32'h23) begin
      errors++;
      $display("[TB] FAIL overrun_stat got %h want 00000023", d);
    end
    axiRead(4'h8, d, r);
    checks++;
    if (d !== 32'h03) begin
      errors++;
      $display("[TB] FAIL overrun_cleared got %h want 00000003", d);
    end
    axiRead(4'h0, d, r);
    checks++;
    if (d !== 32'h60) begin
      errors++;
      $display("[TB] FAIL overrun_first got %h want 00000060", d);
    end
    axiRead(4'h8, d, r);
    checks++;
    if (d !== 32'h01) begin
      errors++;
      $display("[TB] FAIL overrun_after_pop got %h want 00000001", d);
    end
    axiWrite(4'hC, 32'h2, 4'hF, 0, 0, r);
    axiRead(4'h8, d, r);
    checks++;
    if (d !== 32'h00) begin
      errors++;
      $display("[TB] FAIL rx_flush got %h want 00000000", d);
    end
    axiWrite(4'hC, 32'h1, 4'hF, 0, 0, r);
    axiRead(4'h8, d, r);
    checks++;
    if (d !== 32'h04 || TX_VALID !== 1'b0) begin
      errors++;
      $display("[TB] FAIL tx_flush got %h/%b want 00000004/0", d, TX_VALID);
    end
  endtask

  task automatic test_rready_stall();
    logic [1:0] wr;
    int         n;
    TX_READY = 1'b0;
    strobeRx(8'h77);
    fork
      begin
        bus.ARADDR  = 4'h0;
        bus.ARVALID = 1'b1;
        bus.RREADY  = 1'b0;
        n = 0;
        while (bus.ARREADY !== 1'b1 && n < 20) begin step(); n++; end
        step();
        bus.ARVALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
          checks++;
          if ({bus.RVALID, bus.ARREADY} !== 2'b10 || bus.RDATA !== 32'h77) begin
            errors++;
            $display("[TB] FAIL stall_hold%0d got RVALID/ARREADY=%b RDATA=%h want 10/00000077",
                     i, {bus.RVALID, bus.ARREADY}, bus.RDATA);
          end
          step();
        end
        bus.RREADY = 1'b1;
        step();
        bus.RREADY = 1'b0;
        checks++;
        if (bus.RVALID !== 1'b0) begin
          errors++;
          $display("[TB] FAIL stall_release got RVALID=%b want 0", bus.RVALID);
        end
      end
      begin
        axiWrite(4'h4, 32'h33, 4'h1, 0, 0, wr);
      end
    join
    checks++;
    if (wr !== 2'b00 || TX_VALID !== 1'b1 || TX_DATA !== 8'h33) begin
      errors++;
      $display("[TB] FAIL stall_write got %b/%b/%h want 00/1/33", wr, TX_VALID, TX_DATA);
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] d;
    logic [1:0]  r;
    int          n;
    bus.AWADDR  = 4'h4;
    bus.WDATA   = 32'h44;
    bus.WSTRB   = 4'h1;
    bus.AWVALID = 1'b1;
    bus.WVALID  = 1'b1;
    bus.BREADY  = 1'b0;
    step();
    bus.AWVALID = 1'b0;
    bus.WVALID  = 1'b0;
    n = 0;
    while (bus.BVALID !== 1'b1 && n < 20) begin step(); n++; end
    checks++;
    if (bus.BVALID !== 1'b1 || TX_VALID !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midop_setup got BVALID=%b TX_VALID=%b want 1/1", bus.BVALID, TX_VALID);
    end
    RST_N = 1'b0;
    step();
    checks++;
    if (bus.BVALID !== 1'b0 || TX_VALID !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midop_reset got BVALID=%b TX_VALID=%b want 0/0", bus.BVALID, TX_VALID);
    end
    RST_N = 1'b1;
    bus.BREADY = 1'b1;
    step();
    step();
    bus.BREADY = 1'b0;
    checks++;
    if (bus.BVALID !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midop_no_resp got BVALID=%b want 0", bus.BVALID);
    end
    axiRead(4'h8, d, r);
    checks++;
    if (d !== 32'h04) begin
      errors++;
      $display("[TB] FAIL midop_stat got %h want 00000004", d);
    end
  endtask

  initial begin
    RST_N       = 1'b0;
    TX_READY    = 1'b0;
    RX_DATA     = 8'h00;
    RX_VALID    = 1'b0;
    bus.ARADDR  = '0;
    bus.ARVALID = 1'b0;
    bus.RREADY  = 1'b0;
    bus.AWADDR  = '0;
    bus.AWVALID = 1'b0;
    bus.WDATA   = '0;
    bus.WSTRB   = '0;
    bus.WVALID  = 1'b0;
    bus.BREADY  = 1'b0;
    #2;
    test_reset();
    test_rx_read();
    test_tx_write();
    test_misc_regs();
    test_tx_full();
    test_overrun();
    test_rready_stall();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
